// File: rtl/tdm_demux.sv
// Receive side of the TDM serial link: finds frame alignment from the start
// marker, steers each bit into its channel slot and publishes whole frames.
module tdm_demux #(
  parameter int CHANNELS  = 4,
  parameter int SLOT_BITS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          din,
  input  logic                          din_valid,
  input  logic                          frame_start,
  output logic [CHANNELS*SLOT_BITS-1:0] ch_data,
  output logic                          frame_valid,
  output logic                          sync_err,
  output logic                          locked
);

  localparam int FRAME_BITS = CHANNELS * SLOT_BITS;
  localparam int CNT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [FRAME_BITS-1:0] ch_data_q, ch_data_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  sync_err_q, sync_err_d;
  logic                  locked_q, locked_d;

  // Frame bit k lands in channel k/SLOT_BITS, MSB first within the slot.
  function automatic logic [CNT_W-1:0] bit_pos(input logic [CNT_W-1:0] k);
    int unsigned ki;
    ki = 32'(k);
    return CNT_W'((ki / SLOT_BITS) * SLOT_BITS + (SLOT_BITS - 1) - (ki % SLOT_BITS));
  endfunction

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path through
    // the branches below can leave one unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    sh_d          = sh_q;
    ch_data_d     = ch_data_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    locked_d      = locked_q;

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_start) begin
            sh_d                   = '0;
            sh_d[bit_pos(CNT_ZERO)] = din;
            cnt_d                  = CNT_ONE;
            state_d                = RUN;
          end
        end

        RUN: begin
          if (frame_start && (cnt_q != CNT_ZERO)) begin
            // Early marker: abandon the partial frame and restart on this bit.
            sync_err_d             = 1'b1;
            locked_d               = 1'b0;
            sh_d                   = '0;
            sh_d[bit_pos(CNT_ZERO)] = din;
            cnt_d                  = CNT_ONE;
          end else if (!frame_start && (cnt_q == CNT_ZERO)) begin
            sync_err_d = 1'b1;
            locked_d   = 1'b0;
            state_d    = HUNT;
          end else begin
            sh_d[bit_pos(cnt_q)] = din;
            if (cnt_q == CNT_LAST) begin
              // Publish the frame including the bit captured on this beat.
              ch_data_d     = sh_d;
              frame_valid_d = 1'b1;
              locked_d      = 1'b1;
              cnt_d         = CNT_ZERO;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values; the shift register is reset too, so a
    // reset mid-frame leaves no stale bits behind.
    if (rst) begin
      state_q       <= HUNT;
      cnt_q         <= '0;
      sh_q          <= '0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      ch_data_q     <= ch_data_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      locked_q      <= locked_d;
    end
  end

  assign ch_data     = ch_data_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed scenarios plus randomized framing, all checked
// cycle by cycle against a queue-based frame model.
module tb_tdm_demux;

  localparam int CH = 4;
  localparam int SB = 8;
  localparam int FB = CH * SB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic [FB-1:0] ch_data;
  logic          frame_valid;
  logic          sync_err;
  logic          locked;

  always #5 clk = ~clk;

  tdm_demux #(.CHANNELS(CH), .SLOT_BITS(SB)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .ch_data     (ch_data),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int fv_cnt  = 0;
  int se_cnt  = 0;
  int last_fv_cyc = -1;

  // Reference model: the bits of the frame in progress, and the outputs.
  bit            m_in_frame = 1'b0;
  bit            m_bits[$];
  logic [FB-1:0] m_ch = '0;
  bit            m_fv = 1'b0;
  bit            m_se = 1'b0;
  bit            m_lk = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
  endtask

  // Each channel is a byte built MSB first from consecutive received bits.
  function automatic logic [FB-1:0] assemble();
    logic [FB-1:0] res;
    logic [SB-1:0] v;
    res = '0;
    for (int c = 0; c < CH; c++) begin
      v = '0;
      for (int b = 0; b < SB; b++) v = {v[SB-2:0], logic'(m_bits[c*SB+b])};
      res[c*SB +: SB] = v;
    end
    return res;
  endfunction

  task automatic model_step(input bit r, input bit v, input bit d, input bit fs);
    m_fv = 1'b0;
    m_se = 1'b0;
    if (r) begin
      m_in_frame = 1'b0;
      m_bits.delete();
      m_ch = '0;
      m_lk = 1'b0;
      return;
    end
    if (!v) return;
    if (fs) begin
      if (m_in_frame && m_bits.size() != 0) begin
        m_se = 1'b1;
        m_lk = 1'b0;
      end
      m_bits.delete();
      m_bits.push_back(d);
      m_in_frame = 1'b1;
    end else if (m_in_frame) begin
      if (m_bits.size() == 0) begin
        m_se = 1'b1;
        m_lk = 1'b0;
        m_in_frame = 1'b0;
      end else begin
        m_bits.push_back(d);
      end
    end
    if (m_bits.size() == FB) begin
      m_ch = assemble();
      m_fv = 1'b1;
      m_lk = 1'b1;
      m_bits.delete();
    end
  endtask

  // One clock cycle: drive, step the model at the edge, compare after it.
  task automatic beat(input bit r, input bit v, input bit d, input bit fs);
    rst = r; din_valid = v; din = d; frame_start = fs;
    @(posedge clk);
    cyc++;
    model_step(r, v, d, fs);
    #1;
    check("ch_data", 64'(ch_data), 64'(m_ch));
    check("frame_valid", 64'(frame_valid), 64'(m_fv));
    check("sync_err", 64'(sync_err), 64'(m_se));
    check("locked", 64'(locked), 64'(m_lk));
    check("fv_se_excl", 64'(frame_valid & sync_err), 64'd0);
    if (frame_valid) begin fv_cnt++; last_fv_cyc = cyc; end
    if (sync_err) se_cnt++;
  endtask

  // Sends bits [0, nbits) of word; gap_mode 0 none, 1 toggle, 2 random idle.
  task automatic send_frame(input logic [FB-1:0] word, input int gap_mode,
                            input int nbits, input bit mark0, input int mark_at);
    logic [FB-1:0] w;
    int            idx;
    w = word;
    for (int k = 0; k < nbits; k++) begin
      if (gap_mode == 1 && k > 0)
        beat(1'b0, 1'b0, 1'($urandom), 1'($urandom));
      if (gap_mode == 2) begin
        int g;
        g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) beat(1'b0, 1'b0, 1'($urandom), 1'($urandom));
      end
      idx = (k / SB) * SB + (SB - 1) - (k % SB);
      beat(1'b0, 1'b1, w[idx], (k == 0 && mark0) || (k == mark_at));
    end
  endtask

  initial begin
    logic [FB-1:0] w1, w2, w3;
    int t0, fv0, se0;

    // Reset then idle.
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) beat(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    check("idle_ch", 64'(ch_data), 64'd0);
    check("idle_locked", 64'(locked), 64'd0);

    // Known frame, continuous strobe.
    fv0 = fv_cnt;
    send_frame(32'h01FF3CA5, 0, FB, 1'b1, -1);
    check("known_ch", 64'(ch_data), 64'h01FF3CA5);
    check("known_locked", 64'(locked), 64'd1);
    check("known_fv_count", 64'(fv_cnt - fv0), 64'd1);

    // Same frame with the strobe toggling every cycle.
    t0 = cyc;
    fv0 = fv_cnt;
    send_frame(32'h01FF3CA5, 1, FB, 1'b1, -1);
    check("toggle_ch", 64'(ch_data), 64'h01FF3CA5);
    check("toggle_latency", 64'(last_fv_cyc - t0), 64'd63);
    check("toggle_fv_count", 64'(fv_cnt - fv0), 64'd1);

    // Two good frames, then one with the marker missing.
    w1 = $urandom; w2 = $urandom; w3 = $urandom;
    send_frame(w1, 0, FB, 1'b1, -1);
    send_frame(w2, 0, FB, 1'b1, -1);
    se0 = se_cnt;
    send_frame(w3, 0, FB, 1'b0, -1);
    check("nomark_se_count", 64'(se_cnt - se0), 64'd1);
    check("nomark_locked", 64'(locked), 64'd0);
    check("nomark_ch_kept", 64'(ch_data), 64'(w2));
    send_frame(w3, 2, FB, 1'b1, -1);
    check("relock_locked", 64'(locked), 64'd1);
    check("relock_ch", 64'(ch_data), 64'(w3));

    // Marker reasserted at bit 17.
    w1 = $urandom; w2 = $urandom;
    se0 = se_cnt;
    fv0 = fv_cnt;
    send_frame(w1, 0, 17, 1'b1, -1);
    send_frame(w2, 0, FB, 1'b1, -1);
    check("early_se_count", 64'(se_cnt - se0), 64'd1);
    check("early_fv_count", 64'(fv_cnt - fv0), 64'd1);
    check("early_ch", 64'(ch_data), 64'(w2));

    // Reset at bit 20, then resend from bit 0.
    w1 = $urandom;
    send_frame(w1, 0, 20, 1'b1, -1);
    beat(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_ch", 64'(ch_data), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    se0 = se_cnt;
    send_frame(w1, 0, FB, 1'b1, -1);
    check("rst_resend_ch", 64'(ch_data), 64'(w1));
    check("rst_resend_se", 64'(se_cnt - se0), 64'd0);

    // Randomized framing with occasional faults.
    for (int f = 0; f < 40; f++) begin
      int roll, mode;
      roll = $urandom_range(0, 9);
      mode = $urandom_range(0, 2);
      w1 = $urandom;
      case (roll)
        0: send_frame(w1, mode, FB, 1'b0, -1);
        1: send_frame(w1, mode, FB, 1'b1, $urandom_range(1, FB - 1));
        2: begin
          send_frame(w1, mode, $urandom_range(1, FB - 1), 1'b1, -1);
          beat(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        default: send_frame(w1, mode, FB, 1'b1, -1);
      endcase
    end
    for (int i = 0; i < 4; i++) beat(1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
